icache: RTL
===========

Name: icache

Overview:
- Direct-mapped instruction cache between the fetcher's instruction-request port and the shared memory arbiter.
- Accepts one 32-bit PC request at a time and returns the 32-bit instruction word.
- Hits return in 1 cycle. Misses refill the 4-byte line over the 8-bit memory port, then respond.
- Supports whole-cache invalidation for fence.i.

Parameters:
LINES, 64, number of 4-byte lines; power of two, at least 2.
IDX_W, log2(LINES) = 6, index width; tag width = 30-IDX_W.

Ports:
in_clk  input  1  clock
in_rst_n  input  1  asynchronous, active-low reset
in_rdy  input  1  global ready; low freezes the FSM and request acceptance
in_req_valid  input  1  fetcher request strobe (fetcher's out_dispatch_pc_requesting)
in_req_addr  input  32  requested PC; bits [1:0] ignored
out_req_ready  output  1  cache can accept a request (to fetcher's in_pc_req_enable)
out_data_valid  output  1  one-cycle pulse, instruction valid (to fetcher's in_pc_data_enable)
out_data_inst  output  32  instruction word
in_inval  input  1  invalidate all lines
out_mem_rd_en  output  1  byte read request to arbiter
out_mem_addr  output  32  byte address
in_mem_grant  input  1  arbiter accepts this cycle's read
in_mem_data  input  8  read byte, valid exactly 1 cycle after a granted read

Behaviour:
- Reset (async, in_rst_n=0):
  - All valid bits cleared; state IDLE; counters 0.
  - out_data_valid=0, out_mem_rd_en=0, out_mem_addr=0, out_data_inst=0.
  - Tag/data arrays are not reset.
- Address split: index = addr[IDX_W+1:2]; tag = addr[31:IDX_W+2]; line base = {addr[31:2],2'b00}.
- out_req_ready = (state==IDLE) && in_rdy && !in_inval. Combinational.
- Accept = in_req_valid && out_req_ready. The address is latched on accept.
- States: IDLE, FILL.
- IDLE, hit on accept (valid[idx] && tag match):
  - out_data_inst <= data[idx] and out_data_valid <= 1.
  - The pulse appears the cycle after accept; state stays IDLE.
- IDLE, miss on accept: go to FILL; issue_cnt=0, recv_cnt=0.
- IDLE, in_inval=1: clear all valid bits in that single cycle. No request is accepted that cycle.
- FILL, issue side:
  - out_mem_rd_en = (issue_cnt<4) && in_rdy.
  - out_mem_addr = line base + issue_cnt.
  - Both outputs are combinational from registered state.
  - issue_cnt increments on each cycle with rd_en && in_mem_grant.
- FILL, receive side:
  - A byte granted in cycle c is captured at the end of cycle c+1 into byte lane recv_cnt (little-endian: byte 0 is bits [7:0]); recv_cnt then increments.
  - Capture happens even when in_rdy=0.
- FILL, completion: when lane 3 is captured:
  - Write the line (data, tag, valid=1).
  - out_data_inst <= {in_mem_data, lanes 2..0} and out_data_valid <= 1.
  - state <= IDLE.
- Miss latency with continuous grant: accept in cycle t, grants t+1..t+4, data t+2..t+5, out_data_valid in t+6.
- in_rdy=0 in FILL: no new reads issued, counters hold; in-flight byte still captured.
- in_rdy=0 in IDLE: no accept, out_data_valid pulse unaffected.
- in_inval asserted during FILL is ignored; the fetcher holds it until IDLE.
- Reset mid-FILL aborts the refill. The partial line is never marked valid.
- out_data_valid is high for exactly one cycle per accepted request. The fetcher has at most one request outstanding.

Decomposition:
- Shared package def.v: ADDRESS_WIDTH, INSTRUCTION_WIDTH, TRUE/FALSE, ICACHE_LINES, the state encodings, and the byte-count constant 4.
- One natural sub-module, icache_array: tag/valid/data storage with one read port (combinational by index), one write port, and a valid-clear-all input.
- The FSM and counters stay in icache.

Test Plan:
- Cold miss at 0x0000_0000, memory bytes 13 00 00 00, continuous grant -> 4 reads at 0x0..0x3; out_data_valid in t+6 with inst 0x0000_0013; re-request 0x0 hits, valid at t+1.
- Conflict: fill 0x0000_0004, then request 0x0000_0104 (LINES=64, same index 1) -> miss, refill from 0x104..0x107; then 0x4 misses again.
- Grant withheld 3 cycles after the first read -> out_mem_addr holds 0x...1; inst correct; latency +3; exactly one out_data_valid pulse.
- in_rdy=0 for 2 cycles mid-FILL, with one byte in flight -> the in-flight byte is captured, no reads during the stall, final inst correct.
- After 0x8 is cached, pulse in_inval in IDLE -> out_req_ready=0 that cycle; the next request to 0x8 misses and issues 4 reads.
- Assert in_rst_n=0 after 2 bytes of a fill, then release and request the same PC -> full miss (4 reads), no stale valid line, outputs 0 during reset.

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared constants and types for the direct-mapped instruction cache:
//   ADDRESS_WIDTH / INSTRUCTION_WIDTH - bus widths
//   TRUE / FALSE                      - single-bit constants
//   ICACHE_LINES                      - default number of 4-byte lines
//   LINE_BYTES                        - bytes per line (one instruction word)
//   state_e                           - controller state encoding
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int unsigned ADDRESS_WIDTH     = 32;
  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam logic        TRUE              = 1'b1;
  localparam logic        FALSE             = 1'b0;
  localparam int unsigned ICACHE_LINES      = 64;
  localparam int unsigned LINE_BYTES        = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Tag / valid / data storage for the direct-mapped instruction cache.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset (valid bits only)
//   rd_idx_i        - read index; rd_valid_o/rd_tag_o/rd_data_o follow it
//                     combinationally
//   wr_en_i         - write a whole line (tag, data) and mark it valid
//   wr_idx_i/_tag_i/_data_i - write address and contents
//   clr_all_i       - clear every valid bit in one cycle
// -----------------------------------------------------------------------------
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned LINES = ICACHE_LINES,
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned TAG_W = ADDRESS_WIDTH - 2 - IDX_W
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [IDX_W-1:0]             rd_idx_i,
  output logic                         rd_valid_o,
  output logic [TAG_W-1:0]             rd_tag_o,
  output logic [INSTRUCTION_WIDTH-1:0] rd_data_o,
  input  logic                         wr_en_i,
  input  logic [IDX_W-1:0]             wr_idx_i,
  input  logic [TAG_W-1:0]             wr_tag_i,
  input  logic [INSTRUCTION_WIDTH-1:0] wr_data_i,
  input  logic                         clr_all_i
);

  logic [LINES-1:0]             valid_q;
  logic [TAG_W-1:0]             tag_mem  [LINES];
  logic [INSTRUCTION_WIDTH-1:0] data_mem [LINES];

  // Only the valid bits need a reset; stale tags/data are harmless while
  // their valid bit is clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (clr_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= TRUE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_mem[wr_idx_i]  <= wr_tag_i;
      data_mem[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_data_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped instruction cache with 4-byte lines, refilled one byte at a
// time over an 8-bit arbitrated memory port.
// Ports:
//   in_clk, in_rst_n       - clock, asynchronous active-low reset
//   in_rdy                 - global ready; low freezes acceptance and issue
//   in_req_valid/_addr     - fetch request (PC, bits [1:0] ignored)
//   out_req_ready          - a request can be accepted this cycle
//   out_data_valid/_inst   - one-cycle response pulse with instruction word
//   in_inval               - invalidate the whole cache (fence.i)
//   out_mem_rd_en/_addr    - byte read request to the arbiter
//   in_mem_grant           - arbiter accepts this cycle's read
//   in_mem_data            - read byte, valid the cycle after a grant
// -----------------------------------------------------------------------------
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES = ICACHE_LINES,
  parameter int unsigned IDX_W = $clog2(LINES)
) (
  input  logic                         in_clk,
  input  logic                         in_rst_n,
  input  logic                         in_rdy,
  input  logic                         in_req_valid,
  input  logic [ADDRESS_WIDTH-1:0]     in_req_addr,
  output logic                         out_req_ready,
  output logic                         out_data_valid,
  output logic [INSTRUCTION_WIDTH-1:0] out_data_inst,
  input  logic                         in_inval,
  output logic                         out_mem_rd_en,
  output logic [ADDRESS_WIDTH-1:0]     out_mem_addr,
  input  logic                         in_mem_grant,
  input  logic [7:0]                   in_mem_data
);

  localparam int unsigned TAG_W  = ADDRESS_WIDTH - 2 - IDX_W;
  localparam int unsigned RCV_W  = $clog2(LINE_BYTES);
  localparam int unsigned CNT_W  = RCV_W + 1;  // issue count must reach LINE_BYTES
  localparam int unsigned LANE_W = 8 * (LINE_BYTES - 1);

  state_e                         state_q;
  logic [ADDRESS_WIDTH-3:0]       line_q;       // word address of the line being filled
  logic [CNT_W-1:0]               issue_cnt_q;
  logic [CNT_W-1:0]               issue_cnt_d;
  logic [RCV_W-1:0]               recv_cnt_q;
  logic                           inflight_q;   // a byte was granted last cycle
  logic [LANE_W-1:0]              lanes_q;      // bytes 0..2 of the line
  logic                           data_valid_q;
  logic [INSTRUCTION_WIDTH-1:0]   data_inst_q;

  logic [IDX_W-1:0]               req_idx;
  logic [TAG_W-1:0]               req_tag;
  logic [IDX_W-1:0]               fill_idx;
  logic [TAG_W-1:0]               fill_tag;
  logic                           rd_valid;
  logic [TAG_W-1:0]               rd_tag;
  logic [INSTRUCTION_WIDTH-1:0]   rd_data;
  logic                           accept;
  logic                           hit;
  logic                           issue_fire;
  logic                           last_byte;
  logic                           inval_all;
  logic [INSTRUCTION_WIDTH-1:0]   fill_word;

  assign req_idx  = in_req_addr[IDX_W+1:2];
  assign req_tag  = in_req_addr[ADDRESS_WIDTH-1:IDX_W+2];
  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[ADDRESS_WIDTH-3:IDX_W];

  assign out_req_ready = (state_q == ST_IDLE) && in_rdy && !in_inval;
  assign accept        = in_req_valid && out_req_ready;
  assign hit           = rd_valid && (rd_tag == req_tag);

  assign out_mem_rd_en = (state_q == ST_FILL) && (issue_cnt_q < CNT_W'(LINE_BYTES)) && in_rdy;
  assign out_mem_addr  = (state_q == ST_FILL)
                         ? ({line_q, 2'b00} + ADDRESS_WIDTH'(issue_cnt_q))
                         : '0;
  assign issue_fire    = out_mem_rd_en && in_mem_grant;
  assign issue_cnt_d   = issue_cnt_q + CNT_W'(issue_fire);

  // Capture of the top lane completes the line; it does not depend on in_rdy
  // because the byte is already on the bus.
  assign last_byte = (state_q == ST_FILL) && inflight_q && (recv_cnt_q == RCV_W'(LINE_BYTES - 1));
  assign fill_word = {in_mem_data, lanes_q};
  assign inval_all = (state_q == ST_IDLE) && in_inval;

  assign out_data_valid = data_valid_q;
  assign out_data_inst  = data_inst_q;

  icache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_i      (in_clk),
    .rst_ni     (in_rst_n),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (last_byte),
    .wr_idx_i   (fill_idx),
    .wr_tag_i   (fill_tag),
    .wr_data_i  (fill_word),
    .clr_all_i  (inval_all)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      inflight_q   <= FALSE;
      lanes_q      <= '0;
      data_valid_q <= FALSE;
      data_inst_q  <= '0;
    end else begin
      data_valid_q <= FALSE;
      inflight_q   <= issue_fire;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            line_q <= in_req_addr[ADDRESS_WIDTH-1:2];
            if (hit) begin
              data_inst_q  <= rd_data;
              data_valid_q <= TRUE;
            end else begin
              state_q     <= ST_FILL;
              issue_cnt_q <= '0;
              recv_cnt_q  <= '0;
            end
          end
        end
        ST_FILL: begin
          issue_cnt_q <= issue_cnt_d;
          if (inflight_q) begin
            recv_cnt_q <= recv_cnt_q + RCV_W'(1);
            case (recv_cnt_q)
              RCV_W'(0): lanes_q[7:0]   <= in_mem_data;
              RCV_W'(1): lanes_q[15:8]  <= in_mem_data;
              RCV_W'(2): lanes_q[23:16] <= in_mem_data;
              default: begin
                data_inst_q  <= fill_word;
                data_valid_q <= TRUE;
                state_q      <= ST_IDLE;
              end
            endcase
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
